// File: rtl/ariane_pkg.sv
// ariane_pkg: core-wide types and sizes shared by the issue/commit pipeline.
//   NR_SB_ENTRIES  scoreboard depth (power of two)
//   TRANS_ID_BITS  width of a scoreboard transaction id
//   NR_WB_PORTS    number of functional-unit writeback ports
//   exception      exception record carried by instructions and writebacks
//   scoreboard_entry  one in-flight instruction
package ariane_pkg;

    localparam int unsigned NR_SB_ENTRIES = 4;
    localparam int unsigned TRANS_ID_BITS = $clog2(NR_SB_ENTRIES);
    localparam int unsigned NR_WB_PORTS   = 2;

    typedef struct packed {
        logic [63:0] cause;
        logic [63:0] tval;
        logic        valid;
    } exception;

    typedef struct packed {
        logic [63:0]              pc;
        logic [TRANS_ID_BITS-1:0] trans_id;
        logic [3:0]               fu;
        logic [6:0]               op;
        logic [4:0]               rs1;
        logic [4:0]               rs2;
        logic [4:0]               rd;
        logic [63:0]              result;
        logic                     valid;
        exception                 ex;
    } scoreboard_entry;

endpackage

// File: rtl/scoreboard_pkg.sv
// scoreboard_pkg: pointer/counter widths and helpers local to the scoreboard.
//   IdBits   width of head/tail pointers (same as a transaction id)
//   CntBits  width of the occupancy counter (holds 0..NR_ENTRIES)
//   ptr_inc  circular pointer increment, wraps naturally at the power-of-two depth
package scoreboard_pkg;

    localparam int unsigned IdBits  = ariane_pkg::TRANS_ID_BITS;
    localparam int unsigned CntBits = IdBits + 1;

    function automatic logic [IdBits-1:0] ptr_inc(input logic [IdBits-1:0] ptr);
        return ptr + IdBits'(1);
    endfunction

endpackage

// File: rtl/scoreboard_if.sv
// scoreboard_if: decode/issue, writeback, operand lookup and commit signals of the scoreboard.
//   master modport: the pipeline around the scoreboard (drives *_i, observes *_o)
//   slave modport:  the scoreboard itself
// Optional feature macro SB_FORWARD_EN adds rs1_fwd_o / rs2_fwd_o.
interface scoreboard_if #(
    parameter int unsigned NR_WB_PORTS = ariane_pkg::NR_WB_PORTS
);
    logic                                                flush_i;
    ariane_pkg::scoreboard_entry                         instr_i;
    logic                                                instr_valid_i;
    logic                                                instr_ready_o;
    logic [ariane_pkg::TRANS_ID_BITS-1:0]                issued_trans_id_o;
    logic                                                full_o;
    logic [4:0]                                          rs1_i;
    logic [4:0]                                          rs2_i;
    logic                                                rs1_busy_o;
    logic                                                rs2_busy_o;
`ifdef SB_FORWARD_EN
    logic [63:0]                                         rs1_fwd_o;
    logic [63:0]                                         rs2_fwd_o;
`endif
    logic [NR_WB_PORTS-1:0][ariane_pkg::TRANS_ID_BITS-1:0] wb_trans_id_i;
    logic [NR_WB_PORTS-1:0][63:0]                        wb_data_i;
    ariane_pkg::exception [NR_WB_PORTS-1:0]              wb_ex_i;
    logic [NR_WB_PORTS-1:0]                              wb_valid_i;
    ariane_pkg::scoreboard_entry                         commit_instr_o;
    logic                                                commit_valid_o;
    logic                                                commit_ack_i;

    modport master (
        output flush_i, instr_i, instr_valid_i, rs1_i, rs2_i,
               wb_trans_id_i, wb_data_i, wb_ex_i, wb_valid_i, commit_ack_i,
`ifdef SB_FORWARD_EN
        input  rs1_fwd_o, rs2_fwd_o,
`endif
        input  instr_ready_o, issued_trans_id_o, full_o, rs1_busy_o, rs2_busy_o,
               commit_instr_o, commit_valid_o
    );

    modport slave (
        input  flush_i, instr_i, instr_valid_i, rs1_i, rs2_i,
               wb_trans_id_i, wb_data_i, wb_ex_i, wb_valid_i, commit_ack_i,
`ifdef SB_FORWARD_EN
        output rs1_fwd_o, rs2_fwd_o,
`endif
        output instr_ready_o, issued_trans_id_o, full_o, rs1_busy_o, rs2_busy_o,
               commit_instr_o, commit_valid_o
    );
endinterface

// File: rtl/sb_rs_lookup.sv
// sb_rs_lookup: finds the youngest occupied scoreboard entry whose rd matches one source register.
//   rd_i, occupied_i, head_i  scoreboard state (entries are contiguous from head)
//   rs_i                      source register; x0 is never busy
//   busy_o                    source has a pending producer
//   valid_i, result_i, fwd_o  (SB_FORWARD_EN only) a completed youngest producer forwards
//                             its result instead of reporting busy
module sb_rs_lookup
    import scoreboard_pkg::*;
#(
    parameter int unsigned NR_ENTRIES = ariane_pkg::NR_SB_ENTRIES
) (
    input  logic [NR_ENTRIES-1:0][4:0]  rd_i,
    input  logic [NR_ENTRIES-1:0]       occupied_i,
    input  logic [IdBits-1:0]           head_i,
`ifdef SB_FORWARD_EN
    input  logic [NR_ENTRIES-1:0]       valid_i,
    input  logic [NR_ENTRIES-1:0][63:0] result_i,
    output logic [63:0]                 fwd_o,
`endif
    input  logic [4:0]                  rs_i,
    output logic                        busy_o
);
    logic              hit;
    logic [IdBits-1:0] idx;
`ifdef SB_FORWARD_EN
    logic [IdBits-1:0] hit_idx;
`endif

    // Walk oldest to youngest so the last match is the one nearest the tail.
    always_comb begin
        hit = 1'b0;
        idx = '0;
`ifdef SB_FORWARD_EN
        hit_idx = '0;
`endif
        for (int unsigned i = 0; i < NR_ENTRIES; i++) begin
            idx = head_i + IdBits'(i);
            if (occupied_i[idx] && (rd_i[idx] == rs_i)) begin
                hit = 1'b1;
`ifdef SB_FORWARD_EN
                hit_idx = idx;
`endif
            end
        end
    end

`ifdef SB_FORWARD_EN
    assign busy_o = (rs_i != 5'd0) && hit && !valid_i[hit_idx];
    assign fwd_o  = ((rs_i != 5'd0) && hit && valid_i[hit_idx]) ? result_i[hit_idx] : '0;
`else
    assign busy_o = (rs_i != 5'd0) && hit;
`endif

endmodule

// File: rtl/scoreboard.sv
// scoreboard: in-order circular buffer of in-flight instructions between issue and commit.
//   clk_i      clock, rising edge
//   rst_i      asynchronous active-high reset, aborts all in-flight entries
//   sb_io      scoreboard_if.slave: issue (instr_*, issued_trans_id_o, full_o), writeback (wb_*),
//              commit (commit_*), flush, operand busy lookup (rs*_i / rs*_busy_o)
// Optional feature macro SB_FORWARD_EN: completed producers forward results on rs*_fwd_o.
// All outputs depend only on registered state (plus rs*_i for the lookup).
module scoreboard
    import scoreboard_pkg::*;
#(
    parameter int unsigned NR_ENTRIES  = ariane_pkg::NR_SB_ENTRIES,
    parameter int unsigned NR_WB_PORTS = ariane_pkg::NR_WB_PORTS
) (
    input logic         clk_i,
    input logic         rst_i,
    scoreboard_if.slave sb_io
);
    ariane_pkg::scoreboard_entry [NR_ENTRIES-1:0] mem_q, mem_d;
    logic [NR_ENTRIES-1:0]                        occupied_q, occupied_d;
    logic [IdBits-1:0]                            head_q, head_d, tail_q, tail_d;
    logic [CntBits-1:0]                           cnt_q, cnt_d;
    logic                                         full, commit_valid, issue, commit;
    logic [NR_ENTRIES-1:0][4:0]                   rd_vec;
`ifdef SB_FORWARD_EN
    logic [NR_ENTRIES-1:0]                        valid_vec;
    logic [NR_ENTRIES-1:0][63:0]                  result_vec;
`endif

    assign full         = (cnt_q == CntBits'(NR_ENTRIES));
    assign commit_valid = occupied_q[head_q] && mem_q[head_q].valid;
    // No bypass: a full buffer refuses issue even if the head commits this cycle.
    assign issue        = sb_io.instr_valid_i && !full;
    assign commit       = sb_io.commit_ack_i && commit_valid;

    assign sb_io.full_o            = full;
    assign sb_io.instr_ready_o     = !full;
    assign sb_io.issued_trans_id_o = tail_q;
    assign sb_io.commit_valid_o    = commit_valid;
    assign sb_io.commit_instr_o    = mem_q[head_q];

    always_comb begin
        mem_d      = mem_q;
        occupied_d = occupied_q;
        head_d     = head_q;
        tail_d     = tail_q;
        cnt_d      = cnt_q;
        if (sb_io.flush_i) begin
            occupied_d = '0;
            head_d     = '0;
            tail_d     = '0;
            cnt_d      = '0;
        end else begin
            if (commit) begin
                occupied_d[head_q] = 1'b0;
                head_d             = ptr_inc(head_q);
            end
            // Ascending port order lets the higher port win on a shared id.
            for (int unsigned p = 0; p < NR_WB_PORTS; p++) begin
                if (sb_io.wb_valid_i[p] && occupied_q[sb_io.wb_trans_id_i[p]] &&
                    !(commit && (sb_io.wb_trans_id_i[p] == head_q))) begin
                    mem_d[sb_io.wb_trans_id_i[p]].result = sb_io.wb_data_i[p];
                    mem_d[sb_io.wb_trans_id_i[p]].valid  = 1'b1;
                    if (sb_io.wb_ex_i[p].valid) begin
                        mem_d[sb_io.wb_trans_id_i[p]].ex = sb_io.wb_ex_i[p];
                    end
                end
            end
            // The tail slot is unoccupied, so no writeback above can target it.
            if (issue) begin
                mem_d[tail_q]          = sb_io.instr_i;
                mem_d[tail_q].trans_id = tail_q;
                mem_d[tail_q].valid    = 1'b0;
                occupied_d[tail_q]     = 1'b1;
                tail_d                 = ptr_inc(tail_q);
            end
            unique case ({issue, commit})
                2'b10:   cnt_d = cnt_q + CntBits'(1);
                2'b01:   cnt_d = cnt_q - CntBits'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_q      <= '0;
            occupied_q <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            cnt_q      <= '0;
        end else begin
            mem_q      <= mem_d;
            occupied_q <= occupied_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            cnt_q      <= cnt_d;
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < NR_ENTRIES; i++) begin
            rd_vec[i] = mem_q[i].rd;
`ifdef SB_FORWARD_EN
            valid_vec[i]  = mem_q[i].valid;
            result_vec[i] = mem_q[i].result;
`endif
        end
    end

    sb_rs_lookup #(.NR_ENTRIES(NR_ENTRIES)) i_rs1_lookup (
        .rd_i       (rd_vec),
        .occupied_i (occupied_q),
        .head_i     (head_q),
`ifdef SB_FORWARD_EN
        .valid_i    (valid_vec),
        .result_i   (result_vec),
        .fwd_o      (sb_io.rs1_fwd_o),
`endif
        .rs_i       (sb_io.rs1_i),
        .busy_o     (sb_io.rs1_busy_o)
    );

    sb_rs_lookup #(.NR_ENTRIES(NR_ENTRIES)) i_rs2_lookup (
        .rd_i       (rd_vec),
        .occupied_i (occupied_q),
        .head_i     (head_q),
`ifdef SB_FORWARD_EN
        .valid_i    (valid_vec),
        .result_i   (result_vec),
        .fwd_o      (sb_io.rs2_fwd_o),
`endif
        .rs_i       (sb_io.rs2_i),
        .busy_o     (sb_io.rs2_busy_o)
    );

endmodule

// File: tb/tb_scoreboard.sv
// tb_scoreboard: directed scenarios plus a randomized run checked against a queue-based model
// of the in-flight instruction window.
module tb_scoreboard;
    import ariane_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    scoreboard_if #(.NR_WB_PORTS(NR_WB_PORTS)) sb_if ();

    scoreboard #(.NR_ENTRIES(NR_SB_ENTRIES), .NR_WB_PORTS(NR_WB_PORTS)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .sb_io (sb_if)
    );

    typedef struct {
        int              id;
        logic [4:0]      rd;
        logic [63:0]     pc;
        logic [63:0]     result;
        bit              done;
        exception        ex;
    } model_t;

    model_t m_q[$];
    int     m_next;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        sb_if.flush_i       = 1'b0;
        sb_if.instr_i       = '0;
        sb_if.instr_valid_i = 1'b0;
        sb_if.rs1_i         = '0;
        sb_if.rs2_i         = '0;
        sb_if.wb_trans_id_i = '0;
        sb_if.wb_data_i     = '0;
        sb_if.wb_ex_i       = '0;
        sb_if.wb_valid_i    = '0;
        sb_if.commit_ack_i  = 1'b0;
    endtask

    task automatic offer(input logic [4:0] rd, input logic [63:0] res);
        sb_if.instr_i        = '0;
        sb_if.instr_i.rd     = rd;
        sb_if.instr_i.pc     = 64'h1000 + 64'(rd);
        sb_if.instr_i.result = res;
        sb_if.instr_valid_i  = 1'b1;
    endtask

    task automatic wb(input int p, input int id, input logic [63:0] data);
        sb_if.wb_valid_i[p]    = 1'b1;
        sb_if.wb_trans_id_i[p] = TRANS_ID_BITS'(id);
        sb_if.wb_data_i[p]     = data;
        sb_if.wb_ex_i[p]       = '0;
    endtask

    task automatic do_flush();
        idle();
        sb_if.flush_i = 1'b1;
        tick();
        idle();
    endtask

    task automatic test_reset();
        scoreboard_entry zero_e;
        zero_e = '0;
        idle();
        sb_if.rs1_i = 5'd3;
        sb_if.rs2_i = 5'd4;
        tick();
        vectors++; if (sb_if.instr_ready_o !== 1'b1) begin miscompares++;
            $display("FAIL reset_ready: got %b want 1", sb_if.instr_ready_o); end
        vectors++; if (sb_if.full_o !== 1'b0) begin miscompares++;
            $display("FAIL reset_full: got %b want 0", sb_if.full_o); end
        vectors++; if (sb_if.issued_trans_id_o !== '0) begin miscompares++;
            $display("FAIL reset_id: got %0d want 0", sb_if.issued_trans_id_o); end
        vectors++; if (sb_if.commit_valid_o !== 1'b0) begin miscompares++;
            $display("FAIL reset_cvalid: got %b want 0", sb_if.commit_valid_o); end
        vectors++; if (sb_if.commit_instr_o !== zero_e) begin miscompares++;
            $display("FAIL reset_cinstr: got %h want 0", sb_if.commit_instr_o); end
        vectors++; if ({sb_if.rs1_busy_o, sb_if.rs2_busy_o} !== 2'b00) begin miscompares++;
            $display("FAIL reset_busy: got %b want 00", {sb_if.rs1_busy_o, sb_if.rs2_busy_o}); end
        rst = 1'b0;
        idle();
    endtask

    task automatic test_fill();
        for (int k = 0; k < 4; k++) begin
            vectors++; if (sb_if.issued_trans_id_o !== TRANS_ID_BITS'(k)) begin miscompares++;
                $display("FAIL fill_id: got %0d want %0d", sb_if.issued_trans_id_o, k); end
            offer(5'(k + 1), 64'(100 + k));
            tick();
        end
        idle();
        vectors++; if (sb_if.full_o !== 1'b1) begin miscompares++;
            $display("FAIL fill_full: got %b want 1", sb_if.full_o); end
        vectors++; if (sb_if.instr_ready_o !== 1'b0) begin miscompares++;
            $display("FAIL fill_ready: got %b want 0", sb_if.instr_ready_o); end
        offer(5'd9, 64'd0);
        tick();
        idle();
        vectors++; if (sb_if.full_o !== 1'b1) begin miscompares++;
            $display("FAIL fifth_full: got %b want 1", sb_if.full_o); end
        vectors++; if (sb_if.commit_instr_o.rd !== 5'd1) begin miscompares++;
            $display("FAIL fifth_head_rd: got %0d want 1", sb_if.commit_instr_o.rd); end
        sb_if.rs1_i = 5'd9;
        sb_if.rs2_i = 5'd3;
        #1;
        vectors++; if (sb_if.rs1_busy_o !== 1'b0) begin miscompares++;
            $display("FAIL fifth_not_taken: got %b want 0", sb_if.rs1_busy_o); end
        vectors++; if (sb_if.rs2_busy_o !== 1'b1) begin miscompares++;
            $display("FAIL fill_busy_rd3: got %b want 1", sb_if.rs2_busy_o); end
        idle();
    endtask

    task automatic test_out_of_order();
        wb(0, 2, 64'hABCD); tick(); idle();
        vectors++; if (sb_if.commit_valid_o !== 1'b0) begin miscompares++;
            $display("FAIL ooo_wait0: got %b want 0", sb_if.commit_valid_o); end
        wb(1, 0, 64'h10); tick(); idle();
        vectors++; if (sb_if.commit_valid_o !== 1'b1 || sb_if.commit_instr_o.trans_id !== 2'd0)
            begin miscompares++; $display("FAIL ooo_c0: got v=%b id=%0d want v=1 id=0",
                sb_if.commit_valid_o, sb_if.commit_instr_o.trans_id); end
        vectors++; if (sb_if.commit_instr_o.result !== 64'h10) begin miscompares++;
            $display("FAIL ooo_c0_result: got %h want 10", sb_if.commit_instr_o.result); end
        sb_if.commit_ack_i = 1'b1; tick(); idle();
        vectors++; if (sb_if.commit_valid_o !== 1'b0 || sb_if.full_o !== 1'b0) begin
            miscompares++; $display("FAIL ooo_stall1: got v=%b full=%b want 0 0",
                sb_if.commit_valid_o, sb_if.full_o); end
        sb_if.commit_ack_i = 1'b1; tick(); idle();
        vectors++; if (sb_if.commit_instr_o.trans_id !== 2'd1) begin miscompares++;
            $display("FAIL ooo_ack_ignored: got id %0d want 1", sb_if.commit_instr_o.trans_id); end
        wb(0, 1, 64'h11); tick(); idle();
        vectors++; if (sb_if.commit_valid_o !== 1'b1 || sb_if.commit_instr_o.result !== 64'h11)
            begin miscompares++; $display("FAIL ooo_c1: got v=%b res=%h want 1 11",
                sb_if.commit_valid_o, sb_if.commit_instr_o.result); end
        sb_if.commit_ack_i = 1'b1; tick(); idle();
        vectors++; if (sb_if.commit_valid_o !== 1'b1 || sb_if.commit_instr_o.trans_id !== 2'd2 ||
                       sb_if.commit_instr_o.result !== 64'hABCD) begin miscompares++;
            $display("FAIL ooo_c2: got v=%b id=%0d res=%h want 1 2 abcd", sb_if.commit_valid_o,
                sb_if.commit_instr_o.trans_id, sb_if.commit_instr_o.result); end
        sb_if.commit_ack_i = 1'b1; tick(); idle();
        vectors++; if (sb_if.commit_valid_o !== 1'b0 || sb_if.commit_instr_o.trans_id !== 2'd3)
            begin miscompares++; $display("FAIL ooo_c3_pending: got v=%b id=%0d want 0 3",
                sb_if.commit_valid_o, sb_if.commit_instr_o.trans_id); end
    endtask

    task automatic test_wrap();
        do_flush();
        for (int k = 0; k < 6; k++) begin
            vectors++; if (sb_if.issued_trans_id_o !== TRANS_ID_BITS'(k % 4)) begin miscompares++;
                $display("FAIL wrap_id: got %0d want %0d", sb_if.issued_trans_id_o, k % 4); end
            offer(5'(k + 1), 64'd0); tick(); idle();
            wb(0, k % 4, 64'(k)); tick(); idle();
            vectors++; if (sb_if.commit_valid_o !== 1'b1 ||
                           sb_if.commit_instr_o.trans_id !== TRANS_ID_BITS'(k % 4)) begin
                miscompares++; $display("FAIL wrap_commit: got v=%b id=%0d want 1 %0d",
                    sb_if.commit_valid_o, sb_if.commit_instr_o.trans_id, k % 4); end
            sb_if.commit_ack_i = 1'b1; tick(); idle();
        end
        vectors++; if (sb_if.full_o !== 1'b0 || sb_if.commit_valid_o !== 1'b0) begin
            miscompares++; $display("FAIL wrap_empty: got full=%b v=%b want 0 0",
                sb_if.full_o, sb_if.commit_valid_o); end
        for (int k = 0; k < 4; k++) begin
            offer(5'd1, 64'd0); tick(); idle();
            vectors++; if (sb_if.full_o !== (k == 3)) begin miscompares++;
                $display("FAIL wrap_cnt: after %0d issues got full=%b want %b",
                    k + 1, sb_if.full_o, (k == 3)); end
        end
    endtask

    task automatic test_wb_collision();
        do_flush();
        offer(5'd6, 64'd0); tick();
        offer(5'd7, 64'd0); tick(); idle();
        wb(0, 1, 64'd11); wb(1, 1, 64'd22); tick(); idle();
        wb(0, 3, 64'd99); tick(); idle();
        vectors++; if (sb_if.commit_valid_o !== 1'b0 || sb_if.full_o !== 1'b0 ||
                       sb_if.issued_trans_id_o !== 2'd2) begin miscompares++;
            $display("FAIL coll_unocc: got v=%b full=%b id=%0d want 0 0 2",
                sb_if.commit_valid_o, sb_if.full_o, sb_if.issued_trans_id_o); end
        wb(0, 0, 64'd5); tick(); idle();
        vectors++; if (sb_if.commit_valid_o !== 1'b1 || sb_if.commit_instr_o.result !== 64'd5)
            begin miscompares++; $display("FAIL coll_c0: got v=%b res=%0d want 1 5",
                sb_if.commit_valid_o, sb_if.commit_instr_o.result); end
        sb_if.commit_ack_i = 1'b1; tick(); idle();
        vectors++; if (sb_if.commit_instr_o.trans_id !== 2'd1 ||
                       sb_if.commit_instr_o.result !== 64'd22) begin miscompares++;
            $display("FAIL coll_hi_port_wins: got id=%0d res=%0d want 1 22",
                sb_if.commit_instr_o.trans_id, sb_if.commit_instr_o.result); end
        sb_if.commit_ack_i = 1'b1; tick(); idle();
        vectors++; if (sb_if.commit_valid_o !== 1'b0) begin miscompares++;
            $display("FAIL coll_empty: got %b want 0", sb_if.commit_valid_o); end
    endtask

    task automatic test_busy();
        do_flush();
        offer(5'd5, 64'd0); tick();
        offer(5'd0, 64'd0); tick(); idle();
        sb_if.rs1_i = 5'd5; sb_if.rs2_i = 5'd0; #1;
        vectors++; if (sb_if.rs1_busy_o !== 1'b1 || sb_if.rs2_busy_o !== 1'b0) begin
            miscompares++; $display("FAIL busy_pending: got %b%b want 10",
                sb_if.rs1_busy_o, sb_if.rs2_busy_o); end
        idle();
        wb(0, 0, 64'h7); tick(); idle();
        sb_if.rs1_i = 5'd5; #1;
`ifdef SB_FORWARD_EN
        vectors++; if (sb_if.rs1_busy_o !== 1'b0 || sb_if.rs1_fwd_o !== 64'h7) begin
            miscompares++; $display("FAIL busy_fwd: got busy=%b fwd=%h want 0 7",
                sb_if.rs1_busy_o, sb_if.rs1_fwd_o); end
`else
        vectors++; if (sb_if.rs1_busy_o !== 1'b1) begin miscompares++;
            $display("FAIL busy_done: got %b want 1", sb_if.rs1_busy_o); end
`endif
        idle();
        offer(5'd5, 64'd0); tick(); idle();
        sb_if.rs1_i = 5'd5; sb_if.rs2_i = 5'd6; #1;
        vectors++; if (sb_if.rs1_busy_o !== 1'b1 || sb_if.rs2_busy_o !== 1'b0) begin
            miscompares++; $display("FAIL busy_youngest: got %b%b want 10",
                sb_if.rs1_busy_o, sb_if.rs2_busy_o); end
        idle();
    endtask

    task automatic test_flush();
        do_flush();
        offer(5'd1, 64'd0); tick();
        offer(5'd2, 64'd0); tick();
        offer(5'd3, 64'd0); tick(); idle();
        wb(0, 0, 64'd1); tick(); idle();
        offer(5'd4, 64'd0); wb(0, 1, 64'd2);
        sb_if.commit_ack_i = 1'b1; sb_if.flush_i = 1'b1;
        tick(); idle();
        vectors++; if (sb_if.commit_valid_o !== 1'b0 || sb_if.full_o !== 1'b0 ||
                       sb_if.issued_trans_id_o !== 2'd0) begin miscompares++;
            $display("FAIL flush_state: got v=%b full=%b id=%0d want 0 0 0",
                sb_if.commit_valid_o, sb_if.full_o, sb_if.issued_trans_id_o); end
        sb_if.rs1_i = 5'd2; sb_if.rs2_i = 5'd4; #1;
        vectors++; if ({sb_if.rs1_busy_o, sb_if.rs2_busy_o} !== 2'b00) begin miscompares++;
            $display("FAIL flush_busy: got %b%b want 00", sb_if.rs1_busy_o, sb_if.rs2_busy_o); end
        idle();
        offer(5'd8, 64'd0); tick(); idle();
        vectors++; if (sb_if.commit_instr_o.trans_id !== 2'd0 || sb_if.commit_instr_o.rd !== 5'd8 ||
                       sb_if.commit_valid_o !== 1'b0) begin miscompares++;
            $display("FAIL flush_reissue: got id=%0d rd=%0d v=%b want 0 8 0",
                sb_if.commit_instr_o.trans_id, sb_if.commit_instr_o.rd, sb_if.commit_valid_o); end
    endtask

    task automatic test_async_reset();
        scoreboard_entry zero_e;
        zero_e = '0;
        do_flush();
        offer(5'd1, 64'd0); tick();
        offer(5'd2, 64'd0); tick();
        offer(5'd3, 64'd0); tick(); idle();
        wb(0, 0, 64'd1); tick(); idle();
        vectors++; if (sb_if.commit_valid_o !== 1'b1) begin miscompares++;
            $display("FAIL areset_pre: got %b want 1", sb_if.commit_valid_o); end
        #2 rst = 1'b1;
        #1;
        vectors++; if (sb_if.commit_valid_o !== 1'b0 || sb_if.full_o !== 1'b0 ||
                       sb_if.issued_trans_id_o !== 2'd0 || sb_if.commit_instr_o !== zero_e) begin
            miscompares++; $display("FAIL areset_state: got v=%b full=%b id=%0d instr=%h want 0 0 0 0",
                sb_if.commit_valid_o, sb_if.full_o, sb_if.issued_trans_id_o, sb_if.commit_instr_o);
        end
        rst = 1'b0;
        tick();
        vectors++; if (sb_if.commit_valid_o !== 1'b0 || sb_if.instr_ready_o !== 1'b1) begin
            miscompares++; $display("FAIL areset_after: got v=%b rdy=%b want 0 1",
                sb_if.commit_valid_o, sb_if.instr_ready_o); end
    endtask

    task automatic test_random();
        scoreboard_entry e;
        model_t          me;
        logic [4:0]      rs [2];
        logic            exp_busy [2];
        logic [63:0]     exp_fwd [2];
        logic            got_busy [2];
        logic [63:0]     got_fwd [2];
        bit              exp_cv, can_issue, do_commit;
        int              last;
        do_flush();
        m_q.delete();
        m_next = 0;
        for (int n = 0; n < 600; n++) begin
            sb_if.flush_i = ($urandom_range(0, 49) == 0);
            e = '0;
            e.pc = {$urandom, $urandom};
            e.rd = 5'($urandom_range(0, 7));
            e.result = {$urandom, $urandom};
            e.trans_id = TRANS_ID_BITS'($urandom);
            e.valid = 1'($urandom);
            e.ex.valid = ($urandom_range(0, 9) == 0);
            e.ex.cause = 64'($urandom);
            sb_if.instr_i = e;
            sb_if.instr_valid_i = ($urandom_range(0, 9) < 6);
            for (int p = 0; p < NR_WB_PORTS; p++) begin
                sb_if.wb_valid_i[p] = 1'($urandom);
                sb_if.wb_trans_id_i[p] = TRANS_ID_BITS'($urandom_range(0, 3));
                sb_if.wb_data_i[p] = {$urandom, $urandom};
                sb_if.wb_ex_i[p] = '0;
                sb_if.wb_ex_i[p].valid = ($urandom_range(0, 7) == 0);
                sb_if.wb_ex_i[p].cause = 64'($urandom);
                sb_if.wb_ex_i[p].tval = 64'($urandom);
            end
            sb_if.commit_ack_i = ($urandom_range(0, 9) < 7);
            rs[0] = 5'($urandom_range(0, 7));
            rs[1] = 5'($urandom_range(0, 7));
            sb_if.rs1_i = rs[0];
            sb_if.rs2_i = rs[1];
            #1;
            exp_cv = (m_q.size() > 0) && m_q[0].done;
            vectors++; if (sb_if.commit_valid_o !== exp_cv) begin miscompares++;
                $display("FAIL rnd_cvalid @%0d: got %b want %b", n, sb_if.commit_valid_o, exp_cv); end
            vectors++; if (sb_if.full_o !== (m_q.size() == 4) || sb_if.instr_ready_o !== (m_q.size() != 4))
                begin miscompares++; $display("FAIL rnd_full @%0d: got full=%b rdy=%b want size %0d",
                    n, sb_if.full_o, sb_if.instr_ready_o, m_q.size()); end
            vectors++; if (sb_if.issued_trans_id_o !== TRANS_ID_BITS'(m_next)) begin miscompares++;
                $display("FAIL rnd_id @%0d: got %0d want %0d", n, sb_if.issued_trans_id_o, m_next); end
            if (m_q.size() > 0) begin
                vectors++; if (sb_if.commit_instr_o.trans_id !== TRANS_ID_BITS'(m_q[0].id) ||
                               sb_if.commit_instr_o.rd !== m_q[0].rd ||
                               sb_if.commit_instr_o.pc !== m_q[0].pc ||
                               sb_if.commit_instr_o.result !== m_q[0].result ||
                               sb_if.commit_instr_o.ex !== m_q[0].ex) begin miscompares++;
                    $display("FAIL rnd_head @%0d: got id=%0d rd=%0d res=%h exv=%b want %0d %0d %h %b",
                        n, sb_if.commit_instr_o.trans_id, sb_if.commit_instr_o.rd,
                        sb_if.commit_instr_o.result, sb_if.commit_instr_o.ex.valid,
                        m_q[0].id, m_q[0].rd, m_q[0].result, m_q[0].ex.valid); end
            end
            got_busy[0] = sb_if.rs1_busy_o;
            got_busy[1] = sb_if.rs2_busy_o;
`ifdef SB_FORWARD_EN
            got_fwd[0] = sb_if.rs1_fwd_o;
            got_fwd[1] = sb_if.rs2_fwd_o;
`else
            got_fwd[0] = '0;
            got_fwd[1] = '0;
`endif
            for (int r = 0; r < 2; r++) begin
                last = -1;
                foreach (m_q[j]) if (m_q[j].rd == rs[r]) last = j;
`ifdef SB_FORWARD_EN
                exp_busy[r] = (rs[r] != 0) && (last >= 0) && !m_q[last].done;
                exp_fwd[r] = ((rs[r] != 0) && (last >= 0) && m_q[last].done) ? m_q[last].result : '0;
`else
                exp_busy[r] = (rs[r] != 0) && (last >= 0);
                exp_fwd[r] = '0;
`endif
                vectors++; if (got_busy[r] !== exp_busy[r] || got_fwd[r] !== exp_fwd[r]) begin
                    miscompares++; $display("FAIL rnd_busy%0d @%0d rs=%0d: got %b/%h want %b/%h",
                        r + 1, n, rs[r], got_busy[r], got_fwd[r], exp_busy[r], exp_fwd[r]); end
            end
            @(posedge clk);
            if (sb_if.flush_i) begin
                m_q.delete();
                m_next = 0;
            end else begin
                can_issue = sb_if.instr_valid_i && (m_q.size() < 4);
                do_commit = sb_if.commit_ack_i && exp_cv;
                for (int p = 0; p < NR_WB_PORTS; p++) begin
                    if (sb_if.wb_valid_i[p]) begin
                        foreach (m_q[j]) begin
                            if (m_q[j].id == int'(sb_if.wb_trans_id_i[p]) && !(do_commit && j == 0)) begin
                                me = m_q[j];
                                me.result = sb_if.wb_data_i[p];
                                me.done = 1'b1;
                                if (sb_if.wb_ex_i[p].valid) me.ex = sb_if.wb_ex_i[p];
                                m_q[j] = me;
                            end
                        end
                    end
                end
                if (do_commit) void'(m_q.pop_front());
                if (can_issue) begin
                    me.id = m_next;
                    me.rd = e.rd;
                    me.pc = e.pc;
                    me.result = e.result;
                    me.done = 1'b0;
                    me.ex = e.ex;
                    m_q.push_back(me);
                    m_next = (m_next + 1) % 4;
                end
            end
            #1;
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_fill();
        test_out_of_order();
        test_wrap();
        test_wb_collision();
        test_busy();
        test_flush();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
        $fatal(1);
    end

endmodule
